// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// The blank helper walks digits from the top, so a digit blanks only when everything above it is blank.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int              DIGIT_W    = 4;
   localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
   localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

   function automatic logic blank_step(input logic [DIGIT_W-1:0] digit,
                                       input logic               above_blank);
      return (digit == '0) && above_blank;
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit holding 5 or more,
// so the following left shift carries into the next digit at exactly 10.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_in,
   output logic [DIGIT_W-1:0] digit_out
);

   assign digit_out = (digit_in >= ADJ_THRESH) ? (digit_in + ADJ_ADD) : digit_in;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter with valid/ready on both sides and a leading-zero blank mask.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | in_ready=1, waiting for in_valid; out_bcd holds last result
//   SHIFT | adjust + shift one bit per edge, down-counter tracks bits left
//   DONE  | out_valid=1, result held until out_ready
module bin_to_bcd
   import bcd_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int NDIGITS = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DIGIT_W*NDIGITS-1:0]   out_bcd,
   output logic [NDIGITS-1:0]           out_blank,
   output logic                         out_ovf
);

   localparam int BCD_W = DIGIT_W * NDIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e             state_q;
   logic [WIDTH-1:0]   bin_q;
   logic [BCD_W-1:0]   bcd_q;
   logic               ovf_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               in_ready_q;
   logic               out_valid_q;

   logic [BCD_W-1:0]   bcd_adj;
   logic [BCD_W+WIDTH:0] shifted;
   logic [BCD_W-1:0]   bcd_nxt;
   logic [WIDTH-1:0]   bin_nxt;
   logic               ovf_bit;

   for (genvar g = 0; g < NDIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .digit_in  (bcd_q[g*DIGIT_W +: DIGIT_W]),
         .digit_out (bcd_adj[g*DIGIT_W +: DIGIT_W])
      );
   end

   // Trailing zero is the bit shifted into the binary register; MSB is the digit carry-out.
   assign shifted = {bcd_adj, bin_q, 1'b0};
   assign ovf_bit = shifted[BCD_W+WIDTH];
   assign bcd_nxt = shifted[BCD_W+WIDTH-1 -: BCD_W];
   assign bin_nxt = shifted[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         bin_q       <= '0;
         bcd_q       <= '0;
         ovf_q       <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  bin_q      <= in_data;
                  bcd_q      <= '0;
                  ovf_q      <= 1'b0;
                  cnt_q      <= CNT_LOAD;
                  in_ready_q <= 1'b0;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               bin_q <= bin_nxt;
               bcd_q <= bcd_nxt;
               ovf_q <= ovf_q | ovf_bit;
               cnt_q <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   logic               above;
   logic [NDIGITS-1:0] blank;

   // Digit 0 never blanks so a zero result still shows a single "0".
   always_comb begin
      above = 1'b1;
      blank = '0;
      for (int i = NDIGITS - 1; i >= 1; i--) begin
         above    = blank_step(bcd_q[i*DIGIT_W +: DIGIT_W], above);
         blank[i] = above;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_bcd   = bcd_q;
   assign out_ovf   = ovf_q;
   assign out_blank = blank;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed and randomized checks of bin_to_bcd against a decimal reference model.
module tb_bin_to_bcd;

   logic        clk = 1'b0;
   logic        reset;

   logic        in_valid, in_ready, out_valid, out_ready, out_ovf;
   logic [15:0] in_data;
   logic [19:0] out_bcd;
   logic [4:0]  out_blank;

   logic        in_valid4, in_ready4, out_valid4, out_ready4, out_ovf4;
   logic [15:0] in_data4;
   logic [15:0] out_bcd4;
   logic [3:0]  out_blank4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bin_to_bcd #(.WIDTH(16), .NDIGITS(5)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_bcd(out_bcd), .out_blank(out_blank), .out_ovf(out_ovf)
   );

   bin_to_bcd #(.WIDTH(16), .NDIGITS(4)) dut4 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .out_bcd(out_bcd4), .out_blank(out_blank4), .out_ovf(out_ovf4)
   );

   // Reference model: plain decimal arithmetic on the integer value.
   function automatic int unsigned pow10(input int nd);
      int unsigned p = 1;
      for (int i = 0; i < nd; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [31:0] model_bcd(input int unsigned v, input int nd);
      logic [31:0] r = '0;
      int unsigned x = v % pow10(nd);
      for (int i = 0; i < nd; i++) begin
         r = r | (32'(x % 10) << (4 * i));
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [31:0] model_ovf(input int unsigned v, input int nd);
      return (v >= pow10(nd)) ? 32'd1 : 32'd0;
   endfunction

   function automatic logic [31:0] model_blank(input int unsigned v, input int nd);
      int unsigned x = v % pow10(nd);
      int top = -1;
      logic [31:0] m = '0;
      for (int i = 0; i < nd; i++) begin
         if ((x % 10) != 0) top = i;
         x = x / 10;
      end
      for (int i = 1; i < nd; i++) m[i] = (i > top);
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept v on the 5-digit unit and wait for the result; leaves it in DONE.
   task automatic convert(input logic [15:0] v, input string tag);
      int lat = 0;
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_data  = v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      while (!out_valid && lat < 100) begin
         in_data = 16'($urandom);
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd16);
      chk({tag, "_bcd"},   32'(out_bcd),   model_bcd(v, 5));
      chk({tag, "_blank"}, 32'(out_blank), model_blank(v, 5));
      chk({tag, "_ovf"},   32'(out_ovf),   model_ovf(v, 5));
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic convert4(input logic [15:0] v, input string tag);
      int lat = 0;
      in_data4  = v;
      in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      while (!out_valid4 && lat < 100) begin
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd16);
      chk({tag, "_bcd"},   32'(out_bcd4),   model_bcd(v, 4));
      chk({tag, "_blank"}, 32'(out_blank4), model_blank(v, 4));
      chk({tag, "_ovf"},   32'(out_ovf4),   model_ovf(v, 4));
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;
   endtask

   initial begin
      logic [15:0] q[$];
      logic [15:0] d, v;
      logic        acc, take, prev_v;
      int          sent, rcvd, cyc, acc_edge;

      reset      = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      in_valid4  = 1'b0;
      in_data4   = '0;
      out_ready4 = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_bcd",       32'(out_bcd),   32'd0);
      chk("rst_ovf",       32'(out_ovf),   32'd0);

      convert(16'd0, "zero");
      release_out();
      convert(16'd65535, "max");
      release_out();
      chk("idle_keeps_bcd", 32'(out_bcd), model_bcd(65535, 5));
      convert(16'd1234, "v1234");
      release_out();

      convert4(16'd10000, "n4_10000");
      convert4(16'd9999,  "n4_9999");
      convert4(16'd54321, "n4_54321");

      // Stall in DONE with in_valid pulses that must be ignored.
      convert(16'd42, "hold");
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         in_data  = 16'($urandom);
         tick();
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         chk("hold_bcd",       32'(out_bcd),   model_bcd(42, 5));
         chk("hold_in_ready",  32'(in_ready),  32'd0);
      end
      in_valid = 1'b0;
      release_out();
      chk("hold_rel_in_ready",  32'(in_ready),  32'd1);
      chk("hold_rel_out_valid", 32'(out_valid), 32'd0);

      // Reset in the middle of a conversion discards it.
      in_data  = 16'd777;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (7) tick();
      chk("abort_busy", 32'(in_ready), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready",  32'(in_ready),  32'd1);
      chk("abort_bcd",       32'(out_bcd),   32'd0);
      repeat (20) tick();
      chk("abort_no_result", 32'(out_valid), 32'd0);
      convert(16'd5, "after_abort");
      release_out();

      // Random stream with stalls on both sides.
      sent = 0; rcvd = 0; cyc = 0; acc_edge = 0;
      prev_v = out_valid;
      while (rcvd < 1000 && cyc < 60000) begin
         in_valid  = (sent < 1000) ? ($urandom_range(0, 1) == 1) : 1'b0;
         in_data   = 16'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         d    = in_data;
         acc  = in_valid && in_ready;
         take = out_valid && out_ready;
         if (take) begin
            total++;
            assert (q.size() != 0) else begin
               bad++;
               $error("FAIL stream_dup: observed=result with nothing outstanding expected=none");
            end
            if (q.size() != 0) begin
               v = q.pop_front();
               chk("stream_bcd",   32'(out_bcd),   model_bcd(32'(v), 5));
               chk("stream_blank", 32'(out_blank), model_blank(32'(v), 5));
               chk("stream_ovf",   32'(out_ovf),   32'd0);
               rcvd++;
            end
         end
         tick();
         cyc++;
         if (acc) begin
            q.push_back(d);
            sent++;
            acc_edge = cyc;
         end
         if (out_valid && !prev_v) chk("stream_latency", 32'(cyc - acc_edge), 32'd16);
         prev_v = out_valid;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("stream_received", 32'(rcvd),     32'd1000);
      chk("stream_sent",     32'(sent),     32'd1000);
      chk("stream_leftover", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
